simple_dma: RTL and testbench

SIMPLE_DMA -- requirements
Module: simple_dma

---
 rtl/simple_dma_pkg.sv | 28 ++
 rtl/simple_dma_regs.sv | 160 ++++++++++++++++
 rtl/simple_dma.sv | 144 ++++++++++++++
 tb/tb_simple_dma.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_dma_pkg.sv
// Shared definitions for the simple_dma block:
// register offsets, control/status bit positions and FSM encoding.
package simple_dma_pkg;

    localparam logic [9:0] OFF_SRC    = 10'h000;
    localparam logic [9:0] OFF_DST    = 10'h004;
    localparam logic [9:0] OFF_LEN    = 10'h008;
    localparam logic [9:0] OFF_CTRL   = 10'h00C;
    localparam logic [9:0] OFF_STATUS = 10'h010;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    localparam int LEN_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_RD_REQ  = 3'd1;
    localparam state_t S_RD_WAIT = 3'd2;
    localparam state_t S_WR_REQ  = 3'd3;
    localparam state_t S_WR_WAIT = 3'd4;

endpackage

// File: rtl/simple_dma_regs.sv
// Register file of simple_dma: decode, byte-enable writes,
// W1C status bits and the one-cycle registered response.
module simple_dma_regs
    import simple_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    input  logic                    busy_i,
    input  logic                    done_set_i,
    input  logic                    err_set_i,
    output logic [AddressWidth-1:0] src_o,
    output logic [AddressWidth-1:0] dst_o,
    output logic [LEN_W-1:0]        len_o,
    output logic                    irq_en_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    start_o
);

    logic [AddressWidth-1:0] r_src;
    logic [AddressWidth-1:0] r_dst;
    logic [LEN_W-1:0]        r_len;
    logic                    r_irq_en;
    logic                    r_done;
    logic                    r_err;
    logic                    r_rvalid;
    logic [DataWidth-1:0]    r_rdata;
    logic                    r_rerr;

    logic [9:0]              w_off;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_hit;
    logic [DataWidth-1:0]    w_mask;
    logic [AddressWidth-1:0] w_amask;
    logic [AddressWidth-1:0] w_awdata;
    logic [AddressWidth-1:0] w_src_nxt;
    logic [AddressWidth-1:0] w_dst_nxt;
    logic [LEN_W-1:0]        w_len_nxt;
    logic                    w_ctrl_wr;
    logic                    w_stat_wr;
    logic                    w_clr_done;
    logic                    w_clr_err;
    logic [DataWidth-1:0]    w_rdata;
    logic                    w_unused;

    assign w_off    = dev_addr_i[9:0];
    assign w_wr     = dev_req_i & dev_we_i;
    assign w_rd     = dev_req_i & ~dev_we_i;
    assign w_unused = ^dev_addr_i[AddressWidth-1:10];

    // Expand the four byte enables into a bit mask
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (dev_be_i[i]) begin
                w_mask[i*8 +: 8] = 8'hFF;
            end
        end
    end

    assign w_amask   = AddressWidth'(w_mask);
    assign w_awdata  = AddressWidth'(dev_wdata_i);
    assign w_src_nxt = ((r_src & ~w_amask) | (w_awdata & w_amask))
                       & ~AddressWidth'(3);
    assign w_dst_nxt = ((r_dst & ~w_amask) | (w_awdata & w_amask))
                       & ~AddressWidth'(3);
    assign w_len_nxt = (r_len & ~w_mask[LEN_W-1:0])
                       | (dev_wdata_i[LEN_W-1:0] & w_mask[LEN_W-1:0]);

    assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL) & dev_be_i[0];
    assign w_stat_wr  = w_wr & (w_off == OFF_STATUS) & dev_be_i[0];
    assign start_o    = w_ctrl_wr & dev_wdata_i[CTRL_START] & ~busy_i;
    assign w_clr_done = start_o | (w_stat_wr & dev_wdata_i[ST_DONE]);
    assign w_clr_err  = start_o | (w_stat_wr & dev_wdata_i[ST_ERR]);

    assign w_hit = (w_off == OFF_SRC)  | (w_off == OFF_DST)
                 | (w_off == OFF_LEN)  | (w_off == OFF_CTRL)
                 | (w_off == OFF_STATUS);

    // Readback mux; unmapped offsets read as zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_SRC:    w_rdata = DataWidth'(r_src);
            OFF_DST:    w_rdata = DataWidth'(r_dst);
            OFF_LEN:    w_rdata = DataWidth'(r_len);
            OFF_CTRL:   w_rdata[CTRL_IRQ_EN] = r_irq_en;
            OFF_STATUS: begin
                w_rdata[ST_BUSY] = busy_i;
                w_rdata[ST_DONE] = r_done;
                w_rdata[ST_ERR]  = r_err;
            end
            default:    w_rdata = '0;
        endcase
    end

    // Configuration registers; address/length frozen while busy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr && !busy_i && w_off == OFF_SRC) r_src <= w_src_nxt;
            if (w_wr && !busy_i && w_off == OFF_DST) r_dst <= w_dst_nxt;
            if (w_wr && !busy_i && w_off == OFF_LEN) r_len <= w_len_nxt;
            if (w_ctrl_wr) r_irq_en <= dev_wdata_i[CTRL_IRQ_EN];
        end
    end

    // Sticky status flags; a hardware set beats a clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (done_set_i)      r_done <= 1'b1;
            else if (w_clr_done) r_done <= 1'b0;
            if (err_set_i)       r_err  <= 1'b1;
            else if (w_clr_err)  r_err  <= 1'b0;
        end
    end

    // Response is always returned exactly one cycle after the request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_rvalid <= dev_req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
            r_rerr   <= w_rd & ~w_hit;
        end
    end

    assign dev_rvalid_o = r_rvalid;
    assign dev_rdata_o  = r_rdata;
    assign dev_err_o    = r_rerr;
    assign src_o        = r_src;
    assign dst_o        = r_dst;
    assign len_o        = r_len;
    assign irq_en_o     = r_irq_en;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: rtl/simple_dma.sv
// Word-copy DMA engine: reads one word, writes it, repeats,
// with a single bus transaction outstanding at any time.
module simple_dma
    import simple_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    host_req_o,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [3:0]              host_be_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_gnt_i,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i,
    output logic                    dma_intr_o
);

    state_t                  r_state;
    logic [AddressWidth-1:0] r_cur_src;
    logic [AddressWidth-1:0] r_cur_dst;
    logic [LEN_W-1:0]        r_rem;
    logic [DataWidth-1:0]    r_buf;

    logic [AddressWidth-1:0] w_src;
    logic [AddressWidth-1:0] w_dst;
    logic [LEN_W-1:0]        w_len;
    logic                    w_irq_en;
    logic                    w_done;
    logic                    w_err;
    logic                    w_start;
    logic                    w_busy;
    logic                    w_done_set;
    logic                    w_err_set;
    logic                    w_wait;

    simple_dma_regs #(
        .DataWidth    (DataWidth),
        .AddressWidth (AddressWidth)
    ) u_regs (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_be_i     (dev_be_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .busy_i       (w_busy),
        .done_set_i   (w_done_set),
        .err_set_i    (w_err_set),
        .src_o        (w_src),
        .dst_o        (w_dst),
        .len_o        (w_len),
        .irq_en_o     (w_irq_en),
        .done_o       (w_done),
        .err_o        (w_err),
        .start_o      (w_start)
    );

    assign w_busy = (r_state != S_IDLE);
    assign w_wait = (r_state == S_RD_WAIT) | (r_state == S_WR_WAIT);

    assign w_done_set =
        ((r_state == S_IDLE) & w_start & (w_len == '0))
        | ((r_state == S_WR_WAIT) & host_rvalid_i
           & ~host_err_i & (r_rem == 16'd1));

    assign w_err_set = w_wait & host_rvalid_i & host_err_i;

    // Transfer sequencer and address/count datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cur_src <= '0;
            r_cur_dst <= '0;
            r_rem     <= '0;
            r_buf     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cur_src <= w_src;
                        r_cur_dst <= w_dst;
                        r_rem     <= w_len;
                        if (w_len != '0) r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (host_gnt_i) r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_buf   <= host_rdata_i;
                            r_state <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (host_gnt_i) r_state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cur_src <= r_cur_src + AddressWidth'(4);
                            r_cur_dst <= r_cur_dst + AddressWidth'(4);
                            r_rem     <= r_rem - 16'd1;
                            r_state   <= (r_rem == 16'd1) ? S_IDLE
                                                          : S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_req_o   = (r_state == S_RD_REQ) | (r_state == S_WR_REQ);
    assign host_we_o    = (r_state == S_WR_REQ);
    assign host_addr_o  = host_we_o ? r_cur_dst : r_cur_src;
    assign host_be_o    = host_req_o ? 4'hF : 4'h0;
    assign host_wdata_o = r_buf;
    assign dma_intr_o   = w_irq_en & (w_done | w_err);

endmodule

// File: tb/tb_simple_dma.sv
// Self-checking bench for simple_dma: register table, directed
// transfer corner cases and randomized copies against a memory model.
module tb_simple_dma;

    localparam logic [31:0] A_SRC  = 32'h00;
    localparam logic [31:0] A_DST  = 32'h04;
    localparam logic [31:0] A_LEN  = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dev_req_i;
    logic        dev_we_i;
    logic [3:0]  dev_be_i;
    logic [31:0] dev_addr_i;
    logic [31:0] dev_wdata_i;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;
    logic        host_req_o;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_wdata_o;
    logic        host_gnt_i;
    logic        host_rvalid_i;
    logic [31:0] host_rdata_i;
    logic        host_err_i;
    logic        dma_intr_o;

    always #5 clk = ~clk;

    simple_dma dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_be_i     (dev_be_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .host_req_o   (host_req_o),
        .host_addr_o  (host_addr_o),
        .host_we_o    (host_we_o),
        .host_be_o    (host_be_o),
        .host_wdata_o (host_wdata_o),
        .host_gnt_i   (host_gnt_i),
        .host_rvalid_i(host_rvalid_i),
        .host_rdata_i (host_rdata_i),
        .host_err_i   (host_err_i),
        .dma_intr_o   (dma_intr_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus memory seen by the DUT, and the reference model's copy
    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t log_q[$];
    txn_t exp_q[$];
    bit   exp_done;
    bit   exp_err;

    int          gnt_delay  = 0;
    int          err_read   = 0;
    int          rd_count   = 0;
    int          wait_cnt   = 0;
    bit          pending    = 0;
    bit          pend_err   = 0;
    logic [31:0] pend_data;
    int          stab_viol  = 0;
    int          be_viol    = 0;
    int          ostd_viol  = 0;
    int          req_cycles = 0;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;

    // Bus slave: optional grant delay, response one cycle after grant
    initial begin : responder
        host_gnt_i    = 1'b0;
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = '0;
        forever begin
            @(negedge clk);
            host_gnt_i    = 1'b0;
            host_rvalid_i = 1'b0;
            host_err_i    = 1'b0;
            if (rst_n && host_req_o) req_cycles++;
            if (!rst_n) begin
                pending  = 0;
                wait_cnt = 0;
            end else if (pending) begin
                if (host_req_o) ostd_viol++;
                host_rvalid_i = 1'b1;
                host_err_i    = pend_err;
                host_rdata_i  = pend_data;
                pending       = 0;
            end else if (host_req_o) begin
                if (host_be_o !== 4'hF) be_viol++;
                if (wait_cnt == 0) begin
                    hold_addr  = host_addr_o;
                    hold_we    = host_we_o;
                    hold_wdata = host_wdata_o;
                end else if (host_addr_o !== hold_addr
                             || host_we_o !== hold_we
                             || (hold_we && host_wdata_o !== hold_wdata)) begin
                    stab_viol++;
                end
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                end else begin
                    host_gnt_i = 1'b1;
                    wait_cnt   = 0;
                    if (host_we_o) begin
                        mem[widx(host_addr_o)] = host_wdata_o;
                        log_q.push_back({1'b1, host_addr_o, host_wdata_o});
                        pend_err  = 0;
                        pend_data = $urandom;
                    end else begin
                        rd_count++;
                        pend_err  = (rd_count == err_read);
                        pend_data = mem[widx(host_addr_o)];
                        log_q.push_back({1'b0, host_addr_o, pend_data});
                    end
                    pending = 1;
                end
            end
        end
    end

    task automatic dev_acc(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] rdata, output logic err,
                           output logic rv);
        @(negedge clk);
        dev_req_i   = 1'b1;
        dev_we_i    = we;
        dev_addr_i  = addr;
        dev_wdata_i = wdata;
        dev_be_i    = be;
        @(negedge clk);
        dev_req_i = 1'b0;
        dev_we_i  = 1'b0;
        rv    = dev_rvalid_o;
        rdata = dev_rdata_o;
        err   = dev_err_o;
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] r;
        logic e, v;
        dev_acc(1'b1, addr, d, 4'hF, r, e, v);
        chk("wr_rvalid", 32'(v), 32'd1);
    endtask

    task automatic reg_rd(input logic [31:0] addr, output logic [31:0] d);
        logic e, v;
        dev_acc(1'b0, addr, 32'h0, 4'hF, d, e, v);
        chk("rd_rvalid", 32'(v), 32'd1);
    endtask

    // Reference: sequential word copy with optional read error at beat k
    task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input int errk);
        logic [31:0] a, d, w;
        exp_q.delete();
        exp_done = 1;
        exp_err  = 0;
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            w = ref_mem[widx(a)];
            exp_q.push_back({1'b0, a, w});
            if (errk == i + 1) begin
                exp_done = 0;
                exp_err  = 1;
                break;
            end
            ref_mem[widx(d)] = w;
            exp_q.push_back({1'b1, d, w});
        end
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input int dly, input int errk,
                              input bit irq);
        gnt_delay = dly;
        err_read  = errk;
        rd_count  = 0;
        stab_viol = 0;
        be_viol   = 0;
        ostd_viol = 0;
        log_q.delete();
        reg_wr(A_SRC, src);
        reg_wr(A_DST, dst);
        reg_wr(A_LEN, 32'(len));
        reg_wr(A_CTRL, {30'b0, irq, 1'b1});
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int n;
        n = 0;
        do begin
            reg_rd(A_STAT, st);
            n++;
        end while (st[0] && n < 400);
        chk("xfer_busy_end", 32'(st[0]), 32'd0);
    endtask

    task automatic check_xfer(input string tag, input logic [31:0] st,
                              input bit irq);
        int bad;
        chk({tag, "_nlog"}, 32'(log_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < log_q.size(); i++)
            if (i >= exp_q.size() || log_q[i] !== exp_q[i]) bad++;
        chk({tag, "_log"}, 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk({tag, "_mem"}, 32'(bad), 32'd0);
        chk({tag, "_status"}, st & 32'h7, {29'b0, exp_err, exp_done, 1'b0});
        chk({tag, "_intr"}, 32'(dma_intr_o),
            32'(irq & (exp_done | exp_err)));
        chk({tag, "_proto"}, 32'(ostd_viol + be_viol + stab_viol), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] st, rd, s, d;
    logic        e, v;
    int          ln, dl, ek, nwr, snap;
    bit          ir;

    initial begin : main
        rst_n       = 1'b0;
        dev_req_i   = 1'b0;
        dev_we_i    = 1'b0;
        dev_be_i    = 4'h0;
        dev_addr_i  = '0;
        dev_wdata_i = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        ref_mem = mem;

        vt.push_back('{"rst_src",  0, A_SRC,  0, 4'hF, 32'h0, 0});
        vt.push_back('{"rst_dst",  0, A_DST,  0, 4'hF, 32'h0, 0});
        vt.push_back('{"rst_len",  0, A_LEN,  0, 4'hF, 32'h0, 0});
        vt.push_back('{"rst_ctrl", 0, A_CTRL, 0, 4'hF, 32'h0, 0});
        vt.push_back('{"rst_stat", 0, A_STAT, 0, 4'hF, 32'h0, 0});
        vt.push_back('{"wr_src",   1, A_SRC,  32'h12345677, 4'hF, 0, 0});
        vt.push_back('{"rd_src",   0, A_SRC,  0, 4'hF, 32'h12345674, 0});
        vt.push_back('{"wr_dst",   1, A_DST,  32'hABCDEF03, 4'hF, 0, 0});
        vt.push_back('{"rd_dst",   0, A_DST,  0, 4'hF, 32'hABCDEF00, 0});
        vt.push_back('{"wr_len",   1, A_LEN,  32'hFFFF1234, 4'hF, 0, 0});
        vt.push_back('{"rd_len",   0, A_LEN,  0, 4'hF, 32'h00001234, 0});
        vt.push_back('{"wr_len_b1",1, A_LEN,  32'h0000AB00, 4'h2, 0, 0});
        vt.push_back('{"rd_len_b1",0, A_LEN,  0, 4'hF, 32'h0000AB34, 0});
        vt.push_back('{"wr_src_b0",1, A_SRC,  32'hFFFFFFFF, 4'h1, 0, 0});
        vt.push_back('{"rd_src_b0",0, A_SRC,  0, 4'hF, 32'h123456FC, 0});
        vt.push_back('{"wr_ctrl",  1, A_CTRL, 32'h2, 4'hF, 0, 0});
        vt.push_back('{"rd_ctrl",  0, A_CTRL, 0, 4'hF, 32'h2, 0});
        vt.push_back('{"rd_0x14",  0, 32'h14, 0, 4'hF, 32'h0, 1});
        vt.push_back('{"rd_0x3fc", 0, 32'h3FC,0, 4'hF, 32'h0, 1});
        vt.push_back('{"rd_0x02",  0, 32'h02, 0, 4'hF, 32'h0, 1});
        vt.push_back('{"wr_ctrl0", 1, A_CTRL, 32'h0, 4'hF, 0, 0});
        vt.push_back('{"rd_ctrl0", 0, A_CTRL, 0, 4'hF, 32'h0, 0});

        repeat (2) @(negedge clk);
        chk("rst_intr",   32'(dma_intr_o),   32'd0);
        chk("rst_req",    32'(host_req_o),   32'd0);
        chk("rst_rvalid", 32'(dev_rvalid_o), 32'd0);
        chk("rst_err",    32'(dev_err_o),    32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            dev_acc(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, e, v);
            chk({vt[i].name, "_rv"},  32'(v), 32'd1);
            chk({vt[i].name, "_dat"}, rd, vt[i].exp_rd);
            chk({vt[i].name, "_err"}, 32'(e), 32'(vt[i].exp_err));
            @(negedge clk);
            chk({vt[i].name, "_rvdrop"}, 32'(dev_rvalid_o), 32'd0);
        end

        // Zero-wait 4-word copy
        model_xfer(32'h00100000, 32'h00100400, 4, 0);
        start_xfer(32'h00100000, 32'h00100400, 4, 0, 0, 1);
        wait_idle(st);
        check_xfer("zw", st, 1);
        for (int i = 0; i < 4; i++)
            chk("zw_copy", mem[widx(32'h00100400) + i],
                mem[widx(32'h00100000) + i]);

        // Same copy with delayed grants into fresh destination words
        for (int i = 0; i < 4; i++) begin
            mem[widx(32'h00100400) + i]     = $urandom;
            ref_mem[widx(32'h00100400) + i] = mem[widx(32'h00100400) + i];
        end
        model_xfer(32'h00100000, 32'h00100400, 4, 0);
        start_xfer(32'h00100000, 32'h00100400, 4, 3, 0, 0);
        wait_idle(st);
        check_xfer("dly", st, 0);

        // Zero length: no traffic, DONE on the following cycle
        snap = req_cycles;
        reg_wr(A_LEN, 32'h0);
        reg_wr(A_CTRL, 32'h3);
        chk("len0_intr", 32'(dma_intr_o), 32'd1);
        reg_rd(A_STAT, st);
        chk("len0_status", st, 32'h2);
        repeat (10) @(negedge clk);
        chk("len0_noreq", 32'(req_cycles - snap), 32'd0);
        reg_wr(A_STAT, 32'h6);
        reg_rd(A_STAT, st);
        chk("w1c_status", st, 32'h0);
        chk("w1c_intr", 32'(dma_intr_o), 32'd0);

        // Read error on the second beat aborts the copy
        model_xfer(32'h00100800, 32'h00100C00, 4, 2);
        start_xfer(32'h00100800, 32'h00100C00, 4, 0, 2, 1);
        wait_idle(st);
        check_xfer("err", st, 1);
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].we) nwr++;
        chk("err_nwrites", 32'(nwr), 32'd1);

        // Register writes while busy, unmapped read
        model_xfer(32'h00101000, 32'h00101400, 4, 0);
        start_xfer(32'h00101000, 32'h00101400, 4, 3, 0, 0);
        reg_rd(A_STAT, st);
        chk("busy_flag", st & 32'h1, 32'h1);
        reg_wr(A_LEN, 32'h8);
        reg_rd(A_LEN, rd);
        chk("busy_len", rd, 32'h4);
        reg_wr(A_SRC, 32'hDEADBEEC);
        reg_rd(A_SRC, rd);
        chk("busy_src", rd, 32'h00101000);
        dev_acc(1'b0, 32'h14, 32'h0, 4'hF, rd, e, v);
        chk("busy_0x14_dat", rd, 32'h0);
        chk("busy_0x14_err", 32'(e), 32'd1);
        wait_idle(st);
        check_xfer("busy", st, 0);

        // Reset during a pending write request
        start_xfer(32'h00101800, 32'h00101C00, 4, 3, 0, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (host_req_o && host_we_o) break;
        end
        chk("rst_reach_wr", 32'(host_req_o & host_we_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_req", 32'(host_req_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem = mem;
        snap = req_cycles;
        reg_rd(A_SRC, rd);  chk("post_rst_src", rd, 32'h0);
        reg_rd(A_DST, rd);  chk("post_rst_dst", rd, 32'h0);
        reg_rd(A_LEN, rd);  chk("post_rst_len", rd, 32'h0);
        reg_rd(A_CTRL, rd); chk("post_rst_ctrl", rd, 32'h0);
        reg_rd(A_STAT, rd); chk("post_rst_stat", rd, 32'h0);
        repeat (20) @(negedge clk);
        chk("post_rst_noreq", 32'(req_cycles - snap), 32'd0);
        chk("post_rst_intr", 32'(dma_intr_o), 32'd0);

        // Address wrap at the top of the address space
        model_xfer(32'hFFFFFFF8, 32'h00000800, 4, 0);
        start_xfer(32'hFFFFFFF8, 32'h00000800, 4, 1, 0, 1);
        wait_idle(st);
        check_xfer("wrap", st, 1);

        // Randomized copies
        for (int k = 0; k < 8; k++) begin
            s  = 32'h00100000 | (32'($urandom_range(0, 1000)) << 2);
            d  = 32'h00102000 | (32'($urandom_range(0, 1000)) << 2);
            ln = int'($urandom_range(0, 8));
            dl = int'($urandom_range(0, 3));
            ek = 0;
            if (ln > 0 && $urandom_range(0, 2) == 0)
                ek = int'($urandom_range(1, ln));
            ir = 1'($urandom_range(0, 1));
            model_xfer(s, d, ln, ek);
            start_xfer(s, d, ln, dl, ek, ir);
            wait_idle(st);
            check_xfer("rnd", st, ir);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
